// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and register-dump FSM states.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Beat stream carrying (index, value) pairs out of the register-dump controller.
interface reg_dump_ctrl_if #(
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int DATA_W = cpu_pkg::REG_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_index,
        output out_data,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// Freezes the CPU and walks the register file in ascending order, one beat per register.
// Two cycles per register (READ, SEND); SEND holds with stable index/data until out_ready.
module reg_dump_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] ReadReg,
    input  logic [DATA_W-1:0] ReadData,
    output logic              halt_req,
    output logic              busy,
    output logic              done,
    reg_dump_ctrl_if.master   out_if
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       next_state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              clear_idx;
    logic              advance_idx;
    logic              capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        ReadReg     = '0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        clear_idx   = 1'b0;
        advance_idx = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear_idx  = 1'b1;
                    next_state = READ;
                end
            end
            READ: begin
                ReadReg    = idx;
                capture    = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (out_index == LAST_IDX);
                if (out_if.out_ready) begin
                    if (out_index == LAST_IDX) begin
                        next_state = DONE;
                    end else begin
                        advance_idx = 1'b1;
                        next_state  = READ;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // The index only moves on an accepted beat, so it stops at LAST_IDX and never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            if (clear_idx) begin
                idx <= '0;
            end else if (advance_idx) begin
                idx <= idx + 1'b1;
            end
            if (capture) begin
                out_index <= idx;
                out_data  <= ReadData;
            end
        end
    end

    assign halt_req         = busy;
    assign out_if.out_valid = out_valid;
    assign out_if.out_last  = out_last;
    assign out_if.out_index = out_index;
    assign out_if.out_data  = out_data;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: register-file model, write gating on halt_req, beat scoreboard.
module tb_reg_dump_ctrl;

    localparam int NR = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  ReadReg;
    logic [31:0] ReadData;
    logic        halt_req;
    logic        busy;
    logic        done;

    logic        cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;

    logic [31:0] rf   [NR];
    logic [31:0] snap [NR];

    int          tests = 0;
    int          fails = 0;

    int          got_idx [$];
    logic [31:0] got_dat [$];
    bit          got_last[$];
    int          got_cyc [$];
    int          done_cnt;
    int          done_cyc;
    int          idle_cyc;
    int          total_done;

    reg_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) dif ();

    reg_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(5), .DATA_W(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .ReadReg  (ReadReg),
        .ReadData (ReadData),
        .halt_req (halt_req),
        .busy     (busy),
        .done     (done),
        .out_if   (dif)
    );

    always #5 clock = ~clock;

    assign ReadData = rf[ReadReg];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the CPU write port is gated combinationally by halt_req.
    task automatic tick();
        bit pend;
        pend = cpu_we && !halt_req;
        @(posedge clock);
        if (pend) rf[cpu_waddr] = cpu_wdata;
        #1;
    endtask

    // mode 0: ready high, 1: random 50%, 2: ready low for 3 cycles while index 1 is shown.
    task automatic run_dump(input int mode, input bit extra_start, input int abort_at, input int wr_at);
        int   c;
        int   lowcnt;
        bit   r;
        bit   prev_stall;
        int   prev_idx;
        logic [31:0] prev_dat;
        got_idx.delete(); got_dat.delete(); got_last.delete(); got_cyc.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; lowcnt = 0; prev_stall = 0;
        prev_idx = 0; prev_dat = '0;
        for (int i = 0; i < NR; i++) snap[i] = rf[i];
        start = 1'b1;
        tick();
        c = 1;
        while (1) begin
            start = (extra_start && (c == 5 || c == 65));
            if (abort_at != 0 && c == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("abort_busy",   32'(busy),          32'd0);
                chk("abort_halt",   32'(halt_req),      32'd0);
                chk("abort_valid",  32'(dif.out_valid), 32'd0);
                chk("abort_done",   32'(done),          32'd0);
                chk("abort_last",   32'(dif.out_last),  32'd0);
                chk("abort_data",   dif.out_data,       32'd0);
                chk("abort_dcount", 32'(done_cnt),      32'd0);
                return;
            end
            if (!busy) begin
                idle_cyc = c;
                break;
            end
            if (c > 1000) begin
                chk("timeout_cycles", 32'(c), 32'd1000);
                break;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            chk("halt_eq_busy", 32'(halt_req), 32'd1);
            if (prev_stall) begin
                chk("stall_valid", 32'(dif.out_valid), 32'd1);
                chk("stall_index", 32'(dif.out_index), 32'(prev_idx));
                chk("stall_data",  dif.out_data,       prev_dat);
            end
            if (!dif.out_valid && !done)
                chk("readreg_read", 32'(ReadReg), 32'(got_idx.size()));
            else
                chk("readreg_other", 32'(ReadReg), 32'd0);
            if (c == wr_at) begin
                cpu_we = 1'b1;
                chk("halt_at_write", 32'(halt_req), 32'd1);
            end
            case (mode)
                1:       r = 1'($urandom_range(0, 1));
                2:       r = !(dif.out_valid && dif.out_index == 5'd1 && lowcnt < 3);
                default: r = 1'b1;
            endcase
            if (mode == 2 && !r) lowcnt++;
            dif.out_ready = r;
            if (dif.out_valid && r) begin
                got_idx.push_back(int'(dif.out_index));
                got_dat.push_back(dif.out_data);
                got_last.push_back(dif.out_last);
                got_cyc.push_back(c);
            end
            prev_stall = dif.out_valid && !r;
            prev_idx   = int'(dif.out_index);
            prev_dat   = dif.out_data;
            tick();
            cpu_we = 1'b0;
            c++;
        end
        start = 1'b0;
    endtask

    // Expected stream: every register in ascending order, values as held at start.
    task automatic check_dump(input string tag);
        chk({tag, "_beats"}, 32'(got_idx.size()), 32'(NR));
        chk({tag, "_dones"}, 32'(done_cnt), 32'd1);
        for (int k = 0; k < NR && k < got_idx.size(); k++) begin
            chk({tag, "_idx"},  32'(got_idx[k]),  32'(k));
            chk({tag, "_data"}, got_dat[k],       snap[k]);
            chk({tag, "_last"}, 32'(got_last[k]), 32'(k == NR - 1));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dif.out_ready = 1'b0;
        cpu_we = 1'b0; cpu_waddr = 5'd5; cpu_wdata = 32'hDEADBEEF;
        for (int i = 0; i < NR; i++) rf[i] = '0;
        rf[1] = 32'd8; rf[2] = 32'd20;
        tick(); tick();
        reset = 1'b0;

        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_halt",  32'(halt_req),      32'd0);
        chk("rst_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_last",  32'(dif.out_last),  32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_rreg",  32'(ReadReg),       32'd0);
        chk("rst_index", 32'(dif.out_index), 32'd0);
        chk("rst_data",  dif.out_data,       32'd0);

        // Full dump, ready high, blocked write to r5 in cycle 3.
        run_dump(0, 1'b0, 0, 3);
        check_dump("basic");
        if (got_dat.size() > 5) chk("r5_beat", got_dat[5], 32'd0);
        chk("r5_rf", rf[5], 32'd0);
        for (int k = 0; k < got_cyc.size(); k++) chk("basic_cyc", 32'(got_cyc[k]), 32'(2 + 2 * k));
        chk("basic_done_cyc", 32'(done_cyc), 32'd65);
        chk("basic_idle_cyc", 32'(idle_cyc), 32'd66);

        // Back-pressure on beat 1.
        tick();
        run_dump(2, 1'b0, 0, 0);
        check_dump("bp");
        if (got_cyc.size() > 2) begin
            chk("bp_cyc1", 32'(got_cyc[1]), 32'd7);
            chk("bp_cyc2", 32'(got_cyc[2]), 32'd9);
        end
        chk("bp_done_cyc", 32'(done_cyc), 32'd68);

        // Start pulses while busy and during DONE are not queued.
        tick();
        run_dump(0, 1'b1, 0, 0);
        check_dump("restart");
        for (int i = 0; i < 5; i++) begin
            chk("restart_idle", 32'(busy), 32'd0);
            tick();
        end

        // Reset mid-dump, then a fresh dump starts at index 0.
        run_dump(0, 1'b0, 20, 0);
        tick();
        run_dump(0, 1'b0, 0, 0);
        check_dump("after_abort");
        if (got_cyc.size() > 0) chk("after_abort_cyc0", 32'(got_cyc[0]), 32'd2);

        // Random back-pressure over three dumps with random register contents.
        total_done = 0;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < NR; i++) rf[i] = $urandom;
            tick();
            run_dump(1, 1'b0, 0, 0);
            check_dump("rand");
            total_done += done_cnt;
        end
        chk("rand_total_done", 32'(total_done), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Debug register-dump controller; the read-side counterpart to the CPU's 32×32 register file. On a start pulse it freezes the CPU, reads every register in ascending order through one register-file read port, and streams each (index, value) pair out over a valid/ready handshake. Instantiated beside the register file in the single-cycle MIPS top level. Its read-address output is muxed onto the register file's second read port while `halt_req` is high.

## Interface
- `NUM_REGS`, 32, number of registers walked (indices 0..NUM_REGS-1).
- `ADDR_W`, 5, register index width.
- `DATA_W`, 32, register data width.

- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a dump; sampled only in IDLE.
- `ReadReg`  out  ADDR_W  register index driven to the register file read port.
- `ReadData`  in  DATA_W  combinational read data returned for `ReadReg`, valid in the same cycle.
- `halt_req`  out  1  CPU must stall PC and suppress register writes while high.
- `busy`  out  1  dump in progress (any state other than IDLE).
- `out_valid`  out  1  `out_index`/`out_data` hold a valid beat.
- `out_ready`  in  1  consumer accepts the beat when high together with `out_valid`.
- `out_index`  out  ADDR_W  index of the current beat.
- `out_data`  out  DATA_W  captured register value.
- `out_last`  out  1  high with the beat for index NUM_REGS-1.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `start`=1 moves to READ and clears the index counter to 0. Otherwise stay in IDLE.
- READ: drive `ReadReg`=index and capture `ReadData` into the output data register. Move to SEND unconditionally.
- SEND: `out_valid`=1.
  - On `out_ready`=1 at index NUM_REGS-1, go to DONE.
  - On `out_ready`=1 at any other index, increment the index and return to READ.
  - Otherwise hold in SEND with all outputs stable.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `halt_req` = `busy` = 1 in READ, SEND and DONE.
- Register 0 is reported exactly as read. The block does not force it to zero.
- The index counter is ADDR_W wide. It never wraps, because the terminal index ends the walk.
- `out_data` and `out_index` are registered. They never change while `out_valid`=1 and `out_ready`=0.
- `start` while busy is ignored and is not queued.
- `ReadReg` outside READ is 0.

## Timing
- Reset values: state IDLE, index 0, `ReadReg` 0, `out_data` 0, `out_index` 0, `out_valid` 0, `out_last` 0, `halt_req` 0, `busy` 0, `done` 0.
- `start` is sampled at edge 0. READ occupies cycle 1. The first beat is valid in cycle 2.
- Each register costs 2 cycles with `out_ready` held high. A full dump with `out_ready` held high is 64 cycles of beats (cycles 1–64) plus DONE in cycle 65. `busy` drops in cycle 66.
- Back-pressure adds one cycle per cycle that `out_ready` is low in SEND.
- `start` asserted in the same cycle that DONE is active is ignored. A new dump needs `start` while IDLE.
- Reset asserted mid-dump aborts the dump at the next edge with all outputs at reset values. No `done` pulse is produced and there is no partial `out_last`.
- `halt_req` is high from cycle 1 through the DONE cycle inclusive. The CPU must see it before any register write in cycle 1, so the top-level write-enable gate is combinational on `halt_req`.

## Structure
- The shared package `cpu_pkg` holds:
  - the state enum (IDLE, READ, SEND, DONE);
  - the `REG_ADDR_W`=5 and `REG_DATA_W`=32 constants, shared with the register file.
- Single module, no sub-module. The FSM, index counter and output registers are small enough to keep together.
- The read-port mux (`ReadReg2` source select on `halt_req`) lives in the CPU top, not in this block.

## Test plan
- Register file preloaded r0=0, r1=8, r2=20, rest 0; `out_ready` tied high; start pulse → 32 beats in order:
  - indices 0..31 on every other cycle starting at cycle 2;
  - data 0, 8, 20, 0…;
  - `out_last` only on index 31;
  - `done` in cycle 65.
- Back-pressure: `out_ready` low for 3 cycles while index 1 is presented → `out_index`=1 and `out_data`=8 held stable; the index 2 beat appears 1 cycle after `ready` rises plus one READ cycle.
- `start` pulsed again at cycles 5 and 65 → ignored, exactly one dump of 32 beats, one `done`.
- Reset asserted in cycle 20 → next cycle: `busy`=0, `halt_req`=0, `out_valid`=0, no `done`. A subsequent start restarts from index 0.
- CPU write attempt to r5 (value 0xDEADBEEF) during the dump → suppressed; beat 5 reports 0.
- Random `out_ready` (50%) over 3 consecutive dumps → each dump delivers 32 beats, no duplicates or drops, `done` count = 3.
